// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: decode-side inputs, write-back bypass, EX-side outputs.
// master = upstream/downstream environment, slave = the id_ex_reg block.
interface id_ex_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned PERF_W = 32
);
  logic              id_valid;
  logic              id_ready;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_imm;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_is_load;
  logic [XLEN-1:0]   rf_rd1;
  logic [XLEN-1:0]   rf_rd2;
  logic              wb_we;
  logic [4:0]        wb_wa;
  logic [XLEN-1:0]   wb_wd;
  logic              flush;
  logic              ex_ready;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_imm;
  logic [XLEN-1:0]   ex_op1;
  logic [XLEN-1:0]   ex_op2;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_is_load;
  logic              load_use_stall;
  logic [PERF_W-1:0] perf_bubbles;
  logic [PERF_W-1:0] perf_flushes;

  modport master (
    output id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd, id_ctrl, id_is_load,
           rf_rd1, rf_rd2, wb_we, wb_wa, wb_wd, flush, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_rs1, ex_rs2,
           ex_rd, ex_ctrl, ex_is_load, load_use_stall, perf_bubbles, perf_flushes
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd, id_ctrl, id_is_load,
           rf_rd1, rf_rd2, wb_we, wb_wa, wb_wd, flush, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_rs1, ex_rs2,
           ex_rd, ex_ctrl, ex_is_load, load_use_stall, perf_bubbles, perf_flushes
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the RV32I core.
// Captures RF read data with write-back bypass, inserts one bubble per
// load-use hazard, supports valid/ready backpressure and branch flush.
// Optional bubble/flush counters are built when ID_EX_PERF_EN is defined;
// otherwise the perf outputs are tied to zero and no counter flops exist.
module id_ex_reg #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned PERF_W = 32
) (
  input  logic    clk,
  input  logic    rst,
  id_ex_if.slave  bus
);

  logic [XLEN-1:0]   r_ex_pc;
  logic [XLEN-1:0]   r_ex_imm;
  logic [XLEN-1:0]   r_ex_op1;
  logic [XLEN-1:0]   r_ex_op2;
  logic [4:0]        r_ex_rs1;
  logic [4:0]        r_ex_rs2;
  logic [4:0]        r_ex_rd;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic              r_ex_valid;
  logic              r_ex_is_load;

  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;
  logic              w_hazard;
  logic              w_adv;

  // Write-back bypass, load-use detection and advance condition
  always_comb begin
    w_op1 = (bus.wb_we && (bus.wb_wa != 5'd0) && (bus.wb_wa == bus.id_rs1)) ?
            bus.wb_wd : bus.rf_rd1;
    w_op2 = (bus.wb_we && (bus.wb_wa != 5'd0) && (bus.wb_wa == bus.id_rs2)) ?
            bus.wb_wd : bus.rf_rd2;
    w_hazard = bus.id_valid && r_ex_valid && r_ex_is_load && (r_ex_rd != 5'd0) &&
               ((r_ex_rd == bus.id_rs1) || (r_ex_rd == bus.id_rs2));
    w_adv = !r_ex_valid || bus.ex_ready;
  end

  assign bus.id_ready       = w_adv && !w_hazard && !bus.flush;
  assign bus.load_use_stall = w_hazard && !bus.flush;

  // Pipeline register: reset > flush > bubble > latch > drain > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_is_load <= 1'b0;
      r_ex_ctrl    <= '0;
      r_ex_pc      <= '0;
      r_ex_imm     <= '0;
      r_ex_op1     <= '0;
      r_ex_op2     <= '0;
      r_ex_rs1     <= '0;
      r_ex_rs2     <= '0;
      r_ex_rd      <= '0;
    end else if (bus.flush) begin
      r_ex_valid   <= 1'b0;
      r_ex_is_load <= 1'b0;
      r_ex_ctrl    <= '0;
    end else if (w_adv) begin
      if (w_hazard || !bus.id_valid) begin
        // Bubble (or empty slot): clearing ex_valid also clears the hazard next cycle
        r_ex_valid   <= 1'b0;
        r_ex_is_load <= 1'b0;
        r_ex_ctrl    <= '0;
      end else begin
        r_ex_valid   <= 1'b1;
        r_ex_is_load <= bus.id_is_load;
        r_ex_ctrl    <= bus.id_ctrl;
        r_ex_pc      <= bus.id_pc;
        r_ex_imm     <= bus.id_imm;
        r_ex_op1     <= w_op1;
        r_ex_op2     <= w_op2;
        r_ex_rs1     <= bus.id_rs1;
        r_ex_rs2     <= bus.id_rs2;
        r_ex_rd      <= bus.id_rd;
      end
    end
  end

  assign bus.ex_valid   = r_ex_valid;
  assign bus.ex_is_load = r_ex_is_load;
  assign bus.ex_ctrl    = r_ex_ctrl;
  assign bus.ex_pc      = r_ex_pc;
  assign bus.ex_imm     = r_ex_imm;
  assign bus.ex_op1     = r_ex_op1;
  assign bus.ex_op2     = r_ex_op2;
  assign bus.ex_rs1     = r_ex_rs1;
  assign bus.ex_rs2     = r_ex_rs2;
  assign bus.ex_rd      = r_ex_rd;

`ifdef ID_EX_PERF_EN
  logic [PERF_W-1:0] r_perf_bubbles;
  logic [PERF_W-1:0] r_perf_flushes;

  // Event counters, wrapping naturally at 2^PERF_W
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_bubbles <= '0;
      r_perf_flushes <= '0;
    end else if (bus.flush) begin
      r_perf_flushes <= r_perf_flushes + 1'b1;
    end else if (w_adv && w_hazard) begin
      r_perf_bubbles <= r_perf_bubbles + 1'b1;
    end
  end

  assign bus.perf_bubbles = r_perf_bubbles;
  assign bus.perf_flushes = r_perf_flushes;
`else
  assign bus.perf_bubbles = {PERF_W{1'b0}};
  assign bus.perf_flushes = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: table of bypass vectors through a
// scoreboard, then load-use, backpressure, reset-mid-stall and flush sequences.
module tb_id_ex_reg;

  logic clk;
  logic rst;

  id_ex_if #(.XLEN(32), .CTRL_W(16), .PERF_W(32)) bus ();

  id_ex_reg #(.XLEN(32), .CTRL_W(16), .PERF_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef ID_EX_PERF_EN
  localparam logic [31:0] PERF_ONE = 32'd1;
`else
  localparam logic [31:0] PERF_ONE = 32'd0;
`endif

  typedef struct {
    logic [31:0] pc, imm, rd1, rd2, wd;
    logic [4:0]  rs1, rs2, rd, wa;
    logic        we, ld;
    logic [15:0] ctrl;
    logic [31:0] e_op1, e_op2;
  } vec_t;

  typedef struct {
    logic [31:0] pc, imm, op1, op2;
    logic [4:0]  rs1, rs2, rd;
    logic [15:0] ctrl;
    logic        ld;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.id_valid   = 1'b1;
    bus.id_pc      = v.pc;
    bus.id_imm     = v.imm;
    bus.id_rs1     = v.rs1;
    bus.id_rs2     = v.rs2;
    bus.id_rd      = v.rd;
    bus.id_ctrl    = v.ctrl;
    bus.id_is_load = v.ld;
    bus.rf_rd1     = v.rd1;
    bus.rf_rd2     = v.rd2;
    bus.wb_we      = v.we;
    bus.wb_wa      = v.wa;
    bus.wb_wd      = v.wd;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.pc = v.pc; e.imm = v.imm; e.op1 = v.e_op1; e.op2 = v.e_op2;
    e.rs1 = v.rs1; e.rs2 = v.rs2; e.rd = v.rd; e.ctrl = v.ctrl; e.ld = v.ld;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("ex_valid", bus.ex_valid, 32'd1);
      chk("ex_pc", bus.ex_pc, e.pc);
      chk("ex_imm", bus.ex_imm, e.imm);
      chk("ex_op1", bus.ex_op1, e.op1);
      chk("ex_op2", bus.ex_op2, e.op2);
      chk("ex_rs1", bus.ex_rs1, e.rs1);
      chk("ex_rs2", bus.ex_rs2, e.rs2);
      chk("ex_rd", bus.ex_rd, e.rd);
      chk("ex_ctrl", bus.ex_ctrl, e.ctrl);
      chk("ex_is_load", bus.ex_is_load, e.ld);
    end
  endtask

  initial begin
    vec_t ld_v, dep_v, bp_v;

    //           pc        imm       rd1       rd2       wd          rs1 rs2 rd  wa  we    ld    ctrl      op1       op2
    vecs[0] = '{32'h100, 32'h4,    32'h5,    32'h6,    32'h0,     5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 16'h0101, 32'h5,    32'h6};
    vecs[1] = '{32'h104, 32'h8,    32'h11,   32'h22,   32'hAA,    5'd3, 5'd4, 5'd5, 5'd3, 1'b1, 1'b0, 16'h0202, 32'hAA,   32'h22};
    vecs[2] = '{32'h108, 32'hC,    32'h11,   32'h33,   32'hBB,    5'd3, 5'd4, 5'd6, 5'd0, 1'b1, 1'b0, 16'h0303, 32'h11,   32'h33};
    vecs[3] = '{32'h10C, 32'h10,   32'h44,   32'h99,   32'hCAFE,  5'd9, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 16'h0404, 32'hCAFE, 32'hCAFE};
    vecs[4] = '{32'h110, 32'h14,   32'h55,   32'h66,   32'hDEAD,  5'd5, 5'd6, 5'd2, 5'd5, 1'b0, 1'b0, 16'h0505, 32'h55,   32'h66};
    vecs[5] = '{32'h114, 32'h18,   32'h77,   32'h88,   32'hBEEF,  5'd5, 5'd7, 5'd4, 5'd6, 1'b1, 1'b0, 16'h0606, 32'h77,   32'h88};

    ld_v  = '{32'h200, 32'h0,  32'h1000, 32'h0,  32'h0, 5'd1, 5'd2, 5'd7, 5'd0, 1'b0, 1'b1, 16'h0055, 32'h1000, 32'h0};
    dep_v = '{32'h204, 32'h20, 32'h3,    32'h77, 32'h0, 5'd8, 5'd7, 5'd9, 5'd0, 1'b0, 1'b0, 16'h0066, 32'h3,    32'h1234};
    bp_v  = '{32'h300, 32'h30, 32'h123,  32'h456,32'h0, 5'd2, 5'd3, 5'd10,5'd0, 1'b0, 1'b0, 16'h0077, 32'h123,  32'h456};

    rst = 1'b1;
    bus.id_valid = 1'b0; bus.id_pc = '0; bus.id_imm = '0; bus.id_rs1 = '0;
    bus.id_rs2 = '0; bus.id_rd = '0; bus.id_ctrl = '0; bus.id_is_load = 1'b0;
    bus.rf_rd1 = '0; bus.rf_rd2 = '0; bus.wb_we = 1'b0; bus.wb_wa = '0;
    bus.wb_wd = '0; bus.flush = 1'b0; bus.ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ex_valid", bus.ex_valid, 32'd0);
    chk("rst_ex_pc", bus.ex_pc, 32'd0);
    chk("rst_ex_op1", bus.ex_op1, 32'd0);
    chk("rst_ex_ctrl", bus.ex_ctrl, 32'd0);
    chk("rst_id_ready", bus.id_ready, 32'd1);
    chk("rst_perf_bubbles", bus.perf_bubbles, 32'd0);
    chk("rst_perf_flushes", bus.perf_flushes, 32'd0);

    // Back-to-back table vectors: one-cycle latency, full throughput
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(negedge clk);
        check_out();
      end
      apply(vecs[i]);
      #1;
      chk("tbl_id_ready", bus.id_ready, 32'd1);
      push_exp(vecs[i]);
    end
    @(negedge clk);
    check_out();

    // Empty slot: valid/ctrl clear, remaining payload holds
    bus.id_valid = 1'b0;
    bus.wb_we    = 1'b0;
    @(negedge clk);
    chk("idle_ex_valid", bus.ex_valid, 32'd0);
    chk("idle_ex_ctrl", bus.ex_ctrl, 32'd0);
    chk("idle_ex_pc_hold", bus.ex_pc, 32'h114);
    chk("idle_ex_op1_hold", bus.ex_op1, 32'h77);

    // Load-use: one bubble, then dependent instruction with WB bypass
    apply(ld_v);
    push_exp(ld_v);
    @(negedge clk);
    check_out();
    apply(dep_v);
    #1;
    chk("lu_stall", bus.load_use_stall, 32'd1);
    chk("lu_id_ready", bus.id_ready, 32'd0);
    @(negedge clk);
    chk("lu_bubble_valid", bus.ex_valid, 32'd0);
    chk("lu_bubble_ctrl", bus.ex_ctrl, 32'd0);
    chk("lu_bubble_is_load", bus.ex_is_load, 32'd0);
    bus.wb_we = 1'b1; bus.wb_wa = 5'd7; bus.wb_wd = 32'h1234;
    #1;
    chk("lu_stall_cleared", bus.load_use_stall, 32'd0);
    chk("lu_id_ready_again", bus.id_ready, 32'd1);
    push_exp(dep_v);
    @(negedge clk);
    check_out();
    chk("lu_perf_bubbles", bus.perf_bubbles, PERF_ONE);

    // Backpressure: EX payload held three cycles
    bus.ex_ready = 1'b0;
    apply(bp_v);
    #1;
    chk("bp_id_ready", bus.id_ready, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ex_valid", bus.ex_valid, 32'd1);
      chk("bp_ex_pc", bus.ex_pc, 32'h204);
      chk("bp_ex_op2", bus.ex_op2, 32'h1234);
      chk("bp_ex_ctrl", bus.ex_ctrl, 32'h0066);
      chk("bp_id_ready_held", bus.id_ready, 32'd0);
    end

    // Reset during the stall discards the held instruction
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rs_ex_valid", bus.ex_valid, 32'd0);
    chk("rs_ex_pc", bus.ex_pc, 32'd0);
    chk("rs_ex_imm", bus.ex_imm, 32'd0);
    chk("rs_ex_op1", bus.ex_op1, 32'd0);
    chk("rs_ex_op2", bus.ex_op2, 32'd0);
    chk("rs_ex_rd", bus.ex_rd, 32'd0);
    chk("rs_ex_ctrl", bus.ex_ctrl, 32'd0);
    chk("rs_id_ready", bus.id_ready, 32'd1);
    chk("rs_perf_bubbles", bus.perf_bubbles, 32'd0);

    // Flush coincident with a load-use hazard
    bus.ex_ready = 1'b1;
    ld_v.pc = 32'h400;
    apply(ld_v);
    push_exp(ld_v);
    @(negedge clk);
    check_out();
    dep_v.rs1 = 5'd7;
    apply(dep_v);
    bus.flush = 1'b1;
    #1;
    chk("fl_stall_masked", bus.load_use_stall, 32'd0);
    chk("fl_id_ready", bus.id_ready, 32'd0);
    @(negedge clk);
    chk("fl_ex_valid", bus.ex_valid, 32'd0);
    chk("fl_ex_ctrl", bus.ex_ctrl, 32'd0);
    chk("fl_ex_is_load", bus.ex_is_load, 32'd0);
    chk("fl_perf_flushes", bus.perf_flushes, PERF_ONE);
    chk("fl_perf_bubbles", bus.perf_bubbles, 32'd0);
    bus.flush    = 1'b0;
    bus.id_valid = 1'b0;
    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    chk("end_ex_valid", bus.ex_valid, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
